// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for a LEGv8-subset datapath
// sharing one memory port; also tracks retired count, halt and memory timeout.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             ALUsrc,
  output logic [1:0]       ALUop,
  output logic             Mem2Reg,
  output logic             RegWrite,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fault
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_RTYPE, OP_LDUR, OP_STUR, OP_ADDI, OP_CBZ, OP_CBNZ, OP_B, OP_HALT
  } op_e;

  // Checks run in priority order: HALT, full 11-bit matches, ADDI, CB*, B.
  function automatic op_e classify(input logic [10:0] op);
    if (op == 11'b11111111111)                          return OP_HALT;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return OP_RTYPE;
    if (op == 11'b11111000010)                          return OP_LDUR;
    if (op == 11'b11111000000)                          return OP_STUR;
    if (op[10:1] == 10'b1001000100)                     return OP_ADDI;
    if (op[10:3] == 8'b10110100)                        return OP_CBZ;
    if (op[10:3] == 8'b10110101)                        return OP_CBNZ;
    if (op[10:5] == 6'b000101)                          return OP_B;
    return OP_NOP;
  endfunction

  state_e             state_q;
  logic [10:0]        opc_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               halted_q;
  logic               fault_q;

  op_e  dec_op;
  op_e  cur_op;
  logic wait_full;
  logic cb_taken;

  assign dec_op    = classify(opcode);
  assign cur_op    = classify(opc_q);
  assign wait_full = (wait_q == WAIT_W'(TIMEOUT));
  assign cb_taken  = (cur_op == OP_CBZ && zero) || (cur_op == OP_CBNZ && !zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // A ready on the limit cycle completes normally.
          if (mem_ready) begin
            state_q <= S_DECODE;
            wait_q  <= '0;
          end else if (wait_full) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          opc_q <= opcode;
          case (dec_op)
            OP_HALT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            OP_NOP: begin
              state_q   <= S_FETCH;
              retired_q <= retired_q + CNT_W'(1);
            end
            default: state_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cur_op)
            OP_LDUR, OP_STUR:  state_q <= S_MEM;
            OP_RTYPE, OP_ADDI: state_q <= S_WB;
            OP_CBZ, OP_CBNZ, OP_B: begin
              state_q   <= S_FETCH;
              retired_q <= retired_q + CNT_W'(1);
            end
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_q <= '0;
            if (cur_op == OP_LDUR) begin
              state_q <= S_WB;
            end else begin
              state_q   <= S_FETCH;
              retired_q <= retired_q + CNT_W'(1);
            end
          end else if (wait_full) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          retired_q <= retired_q + CNT_W'(1);
        end
        S_HALT, S_FAULT: state_q <= state_q;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes follow the current state combinationally so that mem_ready and zero
  // act within the same cycle; everything is held low while reset is asserted.
  always_comb begin
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    Reg2Loc  = 1'b0;
    ALUsrc   = 1'b0;
    ALUop    = 2'b00;
    Mem2Reg  = 1'b0;
    RegWrite = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: Reg2Loc = (dec_op == OP_STUR) || (dec_op == OP_CBZ) || (dec_op == OP_CBNZ);
        S_EXEC: begin
          case (cur_op)
            OP_LDUR, OP_STUR: ALUsrc = 1'b1;
            OP_RTYPE:         ALUop  = 2'b10;
            OP_ADDI: begin
              ALUop  = 2'b10;
              ALUsrc = 1'b1;
            end
            OP_CBZ, OP_CBNZ: begin
              Reg2Loc = 1'b1;
              ALUop   = 2'b01;
              PCWrite = cb_taken;
              PCSrc   = cb_taken;
            end
            OP_B: begin
              PCWrite = 1'b1;
              PCSrc   = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          IorD     = 1'b1;
          ALUsrc   = 1'b1;
          MemRead  = (cur_op == OP_LDUR);
          MemWrite = (cur_op == OP_STUR);
        end
        S_WB: begin
          RegWrite = 1'b1;
          Mem2Reg  = (cur_op == OP_LDUR);
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign halted  = halted_q;
  assign fault   = fault_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction expected cycle traces built from
// the instruction's phase sequence, directed cases followed by random programs.
module tb_multicycle_sequencer;
  localparam int TIMEOUT = 4;
  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3,
                         ST_WB = 3'd4, ST_HALT = 3'd5, ST_FAULT = 3'd6;
  // Strobe vector: {IorD,MemRead,MemWrite,IRWrite,PCWrite,PCSrc,Reg2Loc,ALUsrc,ALUop[1:0],Mem2Reg,RegWrite}
  localparam logic [11:0] B_IORD = 12'h800, B_MR = 12'h400, B_MW = 12'h200, B_IRW = 12'h100,
                          B_PCW = 12'h080, B_PCS = 12'h040, B_R2L = 12'h020, B_ASRC = 12'h010,
                          B_OP10 = 12'h008, B_OP01 = 12'h004, B_M2R = 12'h002, B_RW = 12'h001;
  localparam int C_NOP = 0, C_R = 1, C_LDUR = 2, C_STUR = 3, C_ADDI = 4, C_CBZ = 5, C_CBNZ = 6,
                 C_B = 7, C_HALT = 8;
  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000,
                          OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000,
                          OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
                          OP_ADDI = 11'b10010001000, OP_CBZ = 11'b10110100000,
                          OP_CBNZ = 11'b10110101000, OP_B = 11'b00010100000,
                          OP_HALT = 11'b11111111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [10:0] opcode;
  always #5 clk = ~clk;

  logic IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUsrc, Mem2Reg, RegWrite;
  logic [1:0] ALUop;
  logic [2:0] state;
  logic [15:0] retired;
  logic halted, fault;
  logic [11:0] dut_sb;
  assign dut_sb = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUsrc, ALUop,
                   Mem2Reg, RegWrite};

  multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .ALUsrc(ALUsrc), .ALUop(ALUop),
    .Mem2Reg(Mem2Reg), .RegWrite(RegWrite), .state(state), .retired(retired),
    .halted(halted), .fault(fault)
  );

  // Narrow-counter copy on the same inputs, used to see the retired count wrap.
  logic w_iord, w_mr, w_mw, w_irw, w_pcw, w_pcs, w_r2l, w_asrc, w_m2r, w_rw, w_halted, w_fault;
  logic [1:0] w_aluop;
  logic [2:0] w_state;
  logic [2:0] w_retired;
  multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IorD(w_iord), .MemRead(w_mr), .MemWrite(w_mw), .IRWrite(w_irw),
    .PCWrite(w_pcw), .PCSrc(w_pcs), .Reg2Loc(w_r2l), .ALUsrc(w_asrc), .ALUop(w_aluop),
    .Mem2Reg(w_m2r), .RegWrite(w_rw), .state(w_state), .retired(w_retired),
    .halted(w_halted), .fault(w_fault)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [14:0] exp_q[$];   // {state, strobes} per cycle
  logic [10:0] opc_q[$];
  logic        rdy_q[$];
  logic        ret_q[$];
  logic        drv_zero;
  int          m_retired;
  bit          need_reset;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_class(input logic [10:0] op);
    if (op == OP_HALT) return C_HALT;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return C_R;
    if (op == OP_LDUR) return C_LDUR;
    if (op == OP_STUR) return C_STUR;
    if (op[10:1] == 10'b1001000100) return C_ADDI;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:3] == 8'b10110101) return C_CBNZ;
    if (op[10:5] == 6'b000101) return C_B;
    return C_NOP;
  endfunction

  task automatic push(input logic [2:0] st, input logic [11:0] sb, input logic rdy,
                      input logic [10:0] opc, input logic ret);
    exp_q.push_back({st, sb});
    rdy_q.push_back(rdy);
    opc_q.push_back(opc);
    ret_q.push_back(ret);
  endtask

  task automatic push_stuck(input logic [2:0] st);
    for (int i = 0; i < 3; i++) push(st, 12'h000, 1'($urandom), 11'($urandom), 1'b0);
    need_reset = 1'b1;
  endtask

  // Expected trace of one instruction: fw/mw are cycles of mem_ready=0 before the
  // memory completes; more than TIMEOUT of them means a fault.
  task automatic build(input logic [10:0] opc, input int fw, input int mw, input logic z,
                       input bit abort_mem);
    int c;
    logic ld;
    logic [11:0] mem_sb;
    c = m_class(opc);
    ld = (c == C_LDUR);
    drv_zero = z;
    for (int i = 0; i < fw && i <= TIMEOUT; i++) push(ST_FETCH, B_MR, 1'b0, 11'($urandom), 1'b0);
    if (fw > TIMEOUT) begin
      push_stuck(ST_FAULT);
      return;
    end
    push(ST_FETCH, B_MR | B_IRW | B_PCW, 1'b1, 11'($urandom), 1'b0);
    push(ST_DECODE, (c == C_STUR || c == C_CBZ || c == C_CBNZ) ? B_R2L : 12'h000,
         1'($urandom), opc, c == C_NOP);
    if (c == C_NOP) return;
    if (c == C_HALT) begin
      push_stuck(ST_HALT);
      return;
    end
    case (c)
      C_LDUR, C_STUR: push(ST_EXEC, B_ASRC, 1'($urandom), 11'($urandom), 1'b0);
      C_R:    push(ST_EXEC, B_OP10, 1'($urandom), 11'($urandom), 1'b0);
      C_ADDI: push(ST_EXEC, B_OP10 | B_ASRC, 1'($urandom), 11'($urandom), 1'b0);
      C_CBZ, C_CBNZ: begin
        logic taken;
        taken = (c == C_CBZ) ? z : !z;
        push(ST_EXEC, B_R2L | B_OP01 | (taken ? (B_PCW | B_PCS) : 12'h000),
             1'($urandom), 11'($urandom), 1'b1);
        return;
      end
      default: begin
        push(ST_EXEC, B_PCW | B_PCS, 1'($urandom), 11'($urandom), 1'b1);
        return;
      end
    endcase
    if (c == C_LDUR || c == C_STUR) begin
      mem_sb = B_IORD | B_ASRC | (ld ? B_MR : B_MW);
      if (abort_mem) begin
        push(ST_MEM, mem_sb, 1'b0, 11'($urandom), 1'b0);
        return;
      end
      for (int i = 0; i < mw && i <= TIMEOUT; i++) push(ST_MEM, mem_sb, 1'b0, 11'($urandom), 1'b0);
      if (mw > TIMEOUT) begin
        push_stuck(ST_FAULT);
        return;
      end
      push(ST_MEM, mem_sb, 1'b1, 11'($urandom), c == C_STUR);
      if (c == C_STUR) return;
    end
    push(ST_WB, B_RW | (ld ? B_M2R : 12'h000), 1'($urandom), 11'($urandom), 1'b1);
  endtask

  // ---------------- driver ----------------
  task automatic run_q();
    logic [14:0] e;
    logic r, rt;
    logic [10:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      o = opc_q.pop_front();
      rt = ret_q.pop_front();
      @(negedge clk);
      reset = 1'b0;
      opcode = o;
      mem_ready = r;
      zero = drv_zero;
      #1;
      check("state", 32'(state), 32'(e[14:12]));
      check("strobes", 32'(dut_sb), 32'(e[11:0]));
      check("retired", 32'(retired), 32'(m_retired % 65536));
      check("retired_wrap3", 32'(w_retired), 32'(m_retired % 8));
      check("halted", 32'(halted), 32'(e[14:12] == ST_HALT));
      check("fault", 32'(fault), 32'(e[14:12] == ST_FAULT));
      if (rt) m_retired++;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'($urandom);
      opcode = 11'($urandom);
      zero = 1'($urandom);
      #1;
      check("reset_strobes", 32'(dut_sb), 32'h0);
    end
    m_retired = 0;
    need_reset = 1'b0;
  endtask

  task automatic exec_instr(input logic [10:0] opc, input int fw, input int mw, input logic z);
    build(opc, fw, mw, z, 1'b0);
    run_q();
    if (need_reset) do_reset(1);
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 15) == 0) return TIMEOUT + 1;
    return int'($urandom_range(0, TIMEOUT));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] rop;
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_ADD;
    zero = 1'b0;
    m_retired = 0;
    need_reset = 1'b0;
    do_reset(2);

    exec_instr(OP_ADD, 0, 0, 1'b0);
    exec_instr(OP_LDUR, 0, 3, 1'b0);
    exec_instr(OP_CBZ, 0, 0, 1'b1);
    exec_instr(OP_CBZ, 1, 0, 1'b0);
    exec_instr(OP_CBNZ, 0, 0, 1'b1);
    exec_instr(OP_CBNZ, 2, 0, 1'b0);
    exec_instr(OP_STUR, 0, 1, 1'b0);
    exec_instr(11'b00000000000, 0, 0, 1'b0);
    exec_instr(OP_B, 0, 0, 1'b1);
    exec_instr(OP_ADDI | 11'b1, 0, 0, 1'b0);
    exec_instr(OP_SUB, 0, 0, 1'b0);
    exec_instr(OP_ADD, TIMEOUT + 1, 0, 1'b0);
    exec_instr(OP_ADD, TIMEOUT, 0, 1'b0);
    exec_instr(OP_LDUR, 0, TIMEOUT, 1'b0);
    exec_instr(OP_STUR, 0, TIMEOUT + 1, 1'b0);
    exec_instr(OP_ORR, 0, 0, 1'b0);
    exec_instr(OP_HALT, 0, 0, 1'b0);
    build(OP_STUR, 0, 2, 1'b0, 1'b1);
    run_q();
    do_reset(1);
    exec_instr(OP_AND, 0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0: rop = OP_ADD;
        1: rop = OP_SUB;
        2: rop = OP_AND;
        3: rop = OP_ORR;
        4: rop = OP_LDUR;
        5: rop = OP_STUR;
        6: rop = {10'b1001000100, 1'($urandom)};
        7: rop = {7'b1011010, 1'($urandom), 3'($urandom)};
        8: rop = {6'b000101, 5'($urandom)};
        default: rop = 11'($urandom);
      endcase
      exec_instr(rop, pick_wait(), pick_wait(), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM controller for the LEGv8-subset datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB sequence.
- All instruction and data traffic goes through one shared memory port, using a ready handshake.
- It drives the datapath control strobes, PC update and IR load, and tracks retired instructions, halt and memory-timeout fault.

Parameters:
- TIMEOUT, 16, maximum cycles a memory request may wait for mem_ready before a fault (≥1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  11  IR[31:21]; valid from DECODE onward.
- zero  in  1  ALU zero flag; combinational, valid during EXEC.
- mem_ready  in  1  shared memory completes the current request this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load IR from memory read data.
- PCWrite  out  1  load PC.
- PCSrc  out  1  PC source: 0 = PC+4, 1 = branch target.
- Reg2Loc  out  1  register read-port-2 select (Rt for STUR/CBZ/CBNZ).
- ALUsrc  out  1  ALU B operand: 0 = register, 1 = immediate.
- ALUop  out  2  00 = add (address), 01 = pass B (compare), 10 = R-type/ADDI function.
- Mem2Reg  out  1  write-back source: 1 = memory data.
- RegWrite  out  1  register file write enable.
- state  out  3  current state encoding (debug).
- retired  out  CNT_W  number of instructions completed; wraps modulo 2^CNT_W.
- halted  out  1  HALT executed; sticky until reset.
- fault  out  1  memory timeout occurred; sticky until reset.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6. Value 7 is unreachable; if reached, the next state is FETCH.
- Reset: state=FETCH, retired=0, halted=0, fault=0, latched opcode cleared, wait counter=0.
- Reset mid-operation aborts any outstanding memory request. No strobes are asserted in the reset cycle.
- Strobe rule: all strobes not listed for a state are 0. Strobes are a function of state, latched opcode, zero and mem_ready only.
- FETCH:
  - IorD=0, MemRead=1.
  - On mem_ready: IRWrite=1, PCWrite=1, PCSrc=0; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch opcode. Reg2Loc=1 if STUR/CBZ/CBNZ.
  - HALT (all ones) → HALT.
  - Recognised opcodes → EXEC.
  - Unrecognised opcodes → FETCH, counted as retired (NOP).
- EXEC:
  - LDUR/STUR: ALUsrc=1, ALUop=00; go to MEM.
  - ADD/SUB/AND/ORR: ALUop=10, ALUsrc=0; go to WB.
  - ADDI: ALUop=10, ALUsrc=1; go to WB.
  - CBZ/CBNZ: Reg2Loc=1, ALUop=01. PCWrite=PCSrc=1 iff (CBZ and zero) or (CBNZ and !zero). Go to FETCH, retire.
  - B: PCWrite=PCSrc=1; go to FETCH, retire.
- MEM:
  - IorD=1, ALUsrc=1, ALUop=00 held.
  - LDUR: MemRead=1; on mem_ready → WB.
  - STUR: MemWrite=1; on mem_ready → FETCH, retire.
- WB: RegWrite=1, Mem2Reg=1 iff LDUR; go to FETCH, retire.
- Opcode matching:
  - B: bits[10:5]=000101.
  - CBZ/CBNZ: bits[10:3]=10110100 / 10110101.
  - ADDI: bits[10:1]=1001000100.
  - Others: full 11-bit match.
  - Priority when multiple patterns match: HALT, full match, ADDI, CB*, B.
- Timeout:
  - The wait counter increments each cycle in FETCH or MEM with mem_ready=0, and clears on mem_ready or state exit.
  - When the counter reaches TIMEOUT with mem_ready still 0 → FAULT, fault=1.
  - mem_ready in the same cycle as the limit completes normally (ready wins).
- HALT/FAULT are absorbing states with all strobes 0.
  - halted=1 in HALT; fault=1 in FAULT.
  - Only reset exits.
  - HALT is not counted in retired.
- retired increments by exactly 1 on the retiring transition edge, from FFFF→0 at CNT_W=16.
- Latency with mem_ready held high:
  - R-type/ADDI/LDUR-less: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ/CBNZ/B: 3 cycles.

Test Plan:
- Reset held 2 cycles, mem_ready=1, opcode=ADD (10001011000) → states 0,1,2,4,0. RegWrite=1 only in WB, ALUop=10, retired=1 after 4 cycles.
- LDUR (11111000010) with mem_ready low for 3 cycles in MEM → MemRead, IorD=1 held for 4 MEM cycles, then WB with Mem2Reg=1, RegWrite=1. Total 8 cycles.
- CBZ with zero=1 → PCWrite=PCSrc=1 in EXEC. CBZ with zero=0 → PCWrite=0, return to FETCH. CBNZ inverts both cases. retired increments each time.
- STUR → MemWrite=1 in MEM, RegWrite never asserted. Opcode 00000000000 → DECODE→FETCH, retired+1, no strobes.
- TIMEOUT=4, mem_ready=0 in FETCH → fault=1, state=6 after 5 cycles, all strobes 0. Reset clears it. Repeat with mem_ready=1 on the limit cycle → no fault.
- HALT (11111111111) → state=5, halted=1, retired unchanged. Further mem_ready/opcode activity is ignored. Reset mid-MEM of STUR → MemWrite drops next cycle, state=0.
